serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: operand/result width in bits, minimum 2.
REQ-002 SHALL provide parameter BITS_PER_CYCLE, default 1: bits summed per RUN cycle; WIDTH is an integer multiple of it.
REQ-003 SHALL provide port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide ports in_valid input 1 and in_ready output 1: operand handshake.
REQ-006 SHALL provide ports a and b, input, WIDTH: operands, two's complement when signed interpretation is used.
REQ-007 SHALL provide port cin  input  1  carry-in.
REQ-008 SHALL provide ports out_valid output 1 and out_ready input 1: result handshake.
REQ-009 SHALL provide port sum  output  WIDTH  registered result.
REQ-010 SHALL provide port cout  output  1  carry out of MSB.
REQ-011 SHALL provide port ovf  output  1  signed overflow, (carry into MSB) XOR (carry out of MSB).

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 SHALL accept operands on an edge with in_valid && in_ready: latch a, b, carry<=cin, step counter<=0, go RUN.
REQ-015 SHALL ignore in_valid and operand ports outside IDLE.
REQ-016 SHALL, each RUN cycle, add the BITS_PER_CYCLE least-significant unprocessed bits of both operands plus the carry register, shift them into the result register from the MSB side, update the carry register.
REQ-017 SHALL perform exactly N = WIDTH/BITS_PER_CYCLE RUN cycles, then go DONE; out_valid rises N cycles after the accepting edge.
REQ-018 SHALL, on entering DONE, present final sum, cout and ovf, and hold them stable while out_valid=1 and out_ready=0.
REQ-019 SHALL leave DONE to IDLE on an edge with out_valid && out_ready; in_ready reasserts the following cycle, with no same-cycle bypass.
REQ-020 SHALL retain sum, cout and ovf after the result handshake until the next DONE entry.
REQ-021 SHALL compute the result modulo 2^WIDTH, with cout the unsigned carry and ovf per REQ-011, identical to a WIDTH-bit ripple adder.

Reset
REQ-022 SHALL, on rst=1 at an edge, force state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, carry and counter 0.
REQ-023 SHALL abort any RUN or DONE transaction on reset and discard it; it is never reported.
REQ-024 SHALL give rst priority over all handshakes in the same cycle.

Configuration
REQ-025 SHALL, when macro SERIAL_ADDER_SUB_EN is defined, add port sub (input, 1), latched at acceptance; sub=1 computes a + ~b + 1, with cin ignored and cout=1 meaning no borrow.
REQ-026 SHALL, without SERIAL_ADDER_SUB_EN, have no sub port and always add; all other behaviour is identical.

Verification
REQ-027 SHALL cover: WIDTH=8, BPC=1; a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0, out_valid exactly 8 cycles after accept.
REQ-028 SHALL cover: WIDTH=8, BPC=1; a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
REQ-029 SHALL cover: WIDTH=8, BPC=4; a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1, ovf=0, latency 2 cycles.
REQ-030 SHALL cover: out_ready held 0 for 5 cycles in DONE -> sum/cout/ovf/out_valid stable, in_ready=0 throughout; out_ready=1 -> IDLE next edge.
REQ-031 SHALL cover: rst=1 on the 3rd RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0; a following transaction computes correctly.
REQ-032 SHALL cover, with SERIAL_ADDER_SUB_EN defined: a=0x05, b=0x07, sub=1, cin=1 -> sum=0xFE, cout=0, ovf=0.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder that sums BITS_PER_CYCLE bits of two
// WIDTH-bit operands per clock, LSB chunk first, through a carry register.
// The result is bit-identical to a WIDTH-bit ripple adder: sum modulo
// 2^WIDTH, cout is the unsigned carry out of the MSB, and ovf is the signed
// overflow (carry into MSB XOR carry out of MSB).
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add a 'sub' input.
// When sub=1 at acceptance, the block computes a + ~b + 1 and ignores cin,
// so cout=1 means "no borrow".
//
// Handshakes: in_ready is high only in IDLE and out_valid only in DONE.
// Both are registered copies of the next-state decode.
module serial_adder #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int BPC   = BITS_PER_CYCLE;
    localparam int STEPS = WIDTH / BPC;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Ripple-add one chunk. Returns {carry into top bit, carry out, sum bits}.
    // The carry into the top bit is needed on the final chunk to form ovf.
    function automatic logic [BPC+1:0] add_chunk(
        input logic [BPC-1:0] x,
        input logic [BPC-1:0] y,
        input logic           c
    );
        logic [BPC:0]   cy;
        logic [BPC-1:0] s;
        cy[0] = c;
        for (int i = 0; i < BPC; i++) begin
            s[i]    = x[i] ^ y[i] ^ cy[i];
            cy[i+1] = (x[i] & y[i]) | (x[i] & cy[i]) | (y[i] & cy[i]);
        end
        return {cy[BPC-1], cy[BPC], s};
    endfunction

    // State and datapath registers
    state_t           state_q,     state_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic             carry_q,     carry_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] res_q,       res_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             cout_q,      cout_d;
    logic             ovf_q,       ovf_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;

    // Combinational helpers
    logic             sub_s;
    logic [BPC+1:0]   chunk_s;
    logic [WIDTH-1:0] res_next_s;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_s = sub;
`else
    assign sub_s = 1'b0;
`endif

    // Chunk adder and result shift: new chunk enters from the MSB side
    always_comb begin
        chunk_s    = add_chunk(a_q[BPC-1:0], b_q[BPC-1:0], carry_q);
        res_next_s = (res_q >> BPC) | (WIDTH'(chunk_s[BPC-1:0]) << (WIDTH - BPC));
    end

    // Next-state, datapath and handshake decode
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = a;
                    // Subtraction folds into the operand latch: invert b and force carry-in.
                    b_d     = sub_s ? ~b : b;
                    carry_d = sub_s ? 1'b1 : cin;
                    cnt_d   = {CNT_W{1'b0}};
                    res_d   = {WIDTH{1'b0}};
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d     = a_q >> BPC;
                b_d     = b_q >> BPC;
                res_d   = res_next_s;
                carry_d = chunk_s[BPC];
                if (cnt_q == LAST_STEP) begin
                    cnt_d   = {CNT_W{1'b0}};
                    sum_d   = res_next_s;
                    cout_d  = chunk_s[BPC];
                    ovf_d   = chunk_s[BPC] ^ chunk_s[BPC+1];
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State register with synchronous reset; reset discards any transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            res_q       <= {WIDTH{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: two instances (WIDTH=8 with 1 and with 4
// bits per cycle) share stimulus; vectors carry hand-computed results.
module tb_serial_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       c;
        logic       v;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       out_ready;

    logic       in_ready1, out_valid1, cout1, ovf1;
    logic [7:0] sum1;
    logic       in_ready4, out_valid4, cout4, ovf4;
    logic [7:0] sum4;

    int checks = 0;
    int errors = 0;

    vec_t vq[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid1), .out_ready(out_ready),
        .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid4), .out_ready(out_ready),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One full transaction on both instances, with a stall in DONE.
    task automatic run_vec(input vec_t v);
        int lat1;
        int lat4;
        @(negedge clk);
        chk("idle_in_ready1", in_ready1, 1);
        chk("idle_in_ready4", in_ready4, 1);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        // Garbage on the operand ports while busy must be ignored.
        @(negedge clk);
        a = ~v.a; b = 8'h5A ^ v.b; cin = ~v.cin; sub = ~v.sub;
        lat1 = 0; lat4 = 0;
        for (int k = 1; k <= 20 && lat1 == 0; k++) begin
            @(posedge clk); #1;
            if (lat4 == 0 && out_valid4) begin
                lat4 = k;
            end else if (lat4 != 0) begin
                chk("stall_sum4", sum4, v.s);
                chk("stall_cout4", cout4, v.c);
                chk("stall_ovf4", ovf4, v.v);
                chk("stall_valid4", out_valid4, 1);
                chk("stall_in_ready4", in_ready4, 0);
            end
            if (lat1 == 0 && out_valid1) lat1 = k;
            if (lat1 == 0) chk("run_in_ready1", in_ready1, 0);
        end
        chk("latency1", lat1, 8);
        chk("latency4", lat4, 2);
        chk("sum1", sum1, v.s);
        chk("cout1", cout1, v.c);
        chk("ovf1", ovf1, v.v);
        chk("sum4", sum4, v.s);
        chk("cout4", cout4, v.c);
        chk("ovf4", ovf4, v.v);
        repeat (5) begin
            @(posedge clk); #1;
            chk("hold_valid1", out_valid1, 1);
            chk("hold_in_ready1", in_ready1, 0);
            chk("hold_sum1", sum1, v.s);
            chk("hold_cout1", cout1, v.c);
            chk("hold_ovf1", ovf1, v.v);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_valid1", out_valid1, 0);
        chk("post_in_ready1", in_ready1, 1);
        chk("post_valid4", out_valid4, 0);
        chk("post_in_ready4", in_ready4, 1);
        chk("retain_sum1", sum1, v.s);
        chk("retain_cout1", cout1, v.c);
        chk("retain_sum4", sum4, v.s);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00;
        cin = 1'b0; sub = 1'b0; out_ready = 1'b0;

        //           a      b      cin   sub   sum    cout  ovf
        vq.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        vq.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        vq.push_back('{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
        vq.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        vq.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        vq.push_back('{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0});
        vq.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
        vq.push_back('{8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        vq.push_back('{8'h3C, 8'hC3, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        vq.push_back('{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0});
        vq.push_back('{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0});
        vq.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready1", in_ready1, 1);
        chk("rst_valid1", out_valid1, 0);
        chk("rst_sum1", sum1, 0);
        chk("rst_cout1", cout1, 0);
        chk("rst_ovf1", ovf1, 0);
        chk("rst_in_ready4", in_ready4, 1);
        chk("rst_valid4", out_valid4, 0);
        chk("rst_sum4", sum4, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) run_vec(vq[i]);

        // Reset on the 3rd RUN cycle aborts the transaction
        @(negedge clk);
        a = 8'h7F; b = 8'h01; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_ready1", in_ready1, 1);
        chk("abort_valid1", out_valid1, 0);
        chk("abort_sum1", sum1, 0);
        chk("abort_cout1", cout1, 0);
        chk("abort_ovf1", ovf1, 0);
        chk("abort_in_ready4", in_ready4, 1);
        chk("abort_valid4", out_valid4, 0);
        chk("abort_sum4", sum4, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_stays_idle1", out_valid1, 0);
            chk("abort_stays_idle4", out_valid4, 0);
        end
        run_vec(vq[5]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
